// File: rtl/multicycle_control.sv
// multicycle_control: steps each RV32 instruction through fetch, decode, execute and write-back,
// counts retired instructions and traps illegal opcodes and fetch timeouts.
module multicycle_control #(
    parameter int FETCH_TIMEOUT = 15,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [6:0]       Op_i,
    input  logic             imem_ack_i,
    output logic             imem_req_o,
    output logic             IRWrite_o,
    output logic             PCWrite_o,
    output logic [1:0]       ALUOp_o,
    output logic             ALUSrc_o,
    output logic             RegWrite_o,
    output logic             busy_o,
    output logic [1:0]       fault_o,
    output logic [CNT_W-1:0] retired_o
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, FAULT} state_t;
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    state_t state;
    logic [7:0] wait_cnt;
    // The instruction register must capture the word in the very cycle memory presents it.
    assign IRWrite_o = (state == FETCH) && imem_ack_i;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            imem_req_o <= 1'b0;
            PCWrite_o  <= 1'b0;
            ALUOp_o    <= 2'b00;
            ALUSrc_o   <= 1'b0;
            RegWrite_o <= 1'b0;
            busy_o     <= 1'b0;
            fault_o    <= 2'b00;
            retired_o  <= '0;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    state      <= FETCH;
                    wait_cnt   <= '0;
                    imem_req_o <= 1'b1;
                    busy_o     <= 1'b1;
                end
                FETCH: if (imem_ack_i) begin
                    state      <= DECODE;
                    imem_req_o <= 1'b0;
                end else if (wait_cnt == 8'(FETCH_TIMEOUT - 1)) begin
                    state      <= FAULT;
                    imem_req_o <= 1'b0;
                    busy_o     <= 1'b0;
                    fault_o    <= 2'b10;
                end else begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
                // The ALU control registers double as the latched opcode decode for EXEC and WB.
                DECODE: if (Op_i == OP_R || Op_i == OP_I) begin
                    state    <= EXEC;
                    ALUOp_o  <= (Op_i == OP_R) ? 2'b10 : 2'b00;
                    ALUSrc_o <= (Op_i == OP_I);
                end else begin
                    state   <= FAULT;
                    busy_o  <= 1'b0;
                    fault_o <= 2'b01;
                end
                EXEC: begin
                    state      <= WB;
                    RegWrite_o <= 1'b1;
                    PCWrite_o  <= 1'b1;
                end
                WB: begin
                    state      <= start_i ? FETCH : IDLE;
                    wait_cnt   <= '0;
                    imem_req_o <= start_i;
                    busy_o     <= start_i;
                    RegWrite_o <= 1'b0;
                    PCWrite_o  <= 1'b0;
                    ALUOp_o    <= 2'b00;
                    ALUSrc_o   <= 1'b0;
                    retired_o  <= retired_o + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized instruction transactions checked against a transaction-level expectation model.
module tb_multicycle_control;
    localparam int FT = 15;
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, ack = 1'b0;
    logic [6:0] op = '0;
    logic req, irw, pcw, alusrc, regw, busy;
    logic [1:0] aluop, fault;
    logic [31:0] retired;
    logic req4, irw4, pcw4, alusrc4, regw4, busy4;
    logic [1:0] aluop4, fault4;
    logic [3:0] retired4;
    int errors = 0, checks = 0;
    int unsigned exp_ret = 0;

    multicycle_control #(.FETCH_TIMEOUT(FT)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .Op_i(op), .imem_ack_i(ack),
        .imem_req_o(req), .IRWrite_o(irw), .PCWrite_o(pcw), .ALUOp_o(aluop), .ALUSrc_o(alusrc),
        .RegWrite_o(regw), .busy_o(busy), .fault_o(fault), .retired_o(retired)
    );
    multicycle_control #(.FETCH_TIMEOUT(FT), .CNT_W(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .Op_i(op), .imem_ack_i(ack),
        .imem_req_o(req4), .IRWrite_o(irw4), .PCWrite_o(pcw4), .ALUOp_o(aluop4), .ALUSrc_o(alusrc4),
        .RegWrite_o(regw4), .busy_o(busy4), .fault_o(fault4), .retired_o(retired4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Control vector order: req, irw, pcw, aluop[1:0], alusrc, regw, busy, fault[1:0].
    task automatic expect_cycle(input string ph, input bit e_req, input bit e_irw, input bit e_busy,
                                input logic [1:0] e_aluop, input bit e_src, input bit e_wr, input logic [1:0] e_fault);
        logic [9:0] e;
        e = {e_req, e_irw, e_wr, e_aluop, e_src, e_wr, e_busy, e_fault};
        #1;
        check({ph, " ctl"}, 32'({req, irw, pcw, aluop, alusrc, regw, busy, fault}), 32'(e));
        check({ph, " ctl4"}, 32'({req4, irw4, pcw4, aluop4, alusrc4, regw4, busy4, fault4}), 32'(e));
        check({ph, " retired"}, retired, exp_ret);
        check({ph, " retired4"}, 32'(retired4), exp_ret % 16);
    endtask

    task automatic noise();
        ack = 1'($urandom);
        op = 7'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'($urandom);
        noise();
        tick();
        rst = 1'b0;
        start = 1'b0;
        exp_ret = 0;
        noise();
        expect_cycle("reset", 0, 0, 0, 2'b00, 0, 0, 2'b00);
        tick();
    endtask

    task automatic idle_cycle(input bit go);
        start = go;
        noise();
        expect_cycle("idle", 0, 0, 0, 2'b00, 0, 0, 2'b00);
        tick();
    endtask

    task automatic fault_hold(input logic [1:0] code);
        for (int i = 0; i < 4; i++) begin
            start = 1'($urandom);
            noise();
            expect_cycle("fault", 0, 0, 0, 2'b00, 0, 0, code);
            tick();
        end
        do_reset();
    endtask

    // Runs one instruction starting in its first FETCH cycle; d is the FETCH cycle index carrying the ack.
    task automatic instr(input int d, input logic [6:0] opc, input bit cont, input bit rst_exec, output bit in_fetch);
        bit acked = 0;
        bit is_r = (opc == OP_R);
        in_fetch = 0;
        for (int k = 0; k < FT; k++) begin
            ack = (k == d);
            op = 7'($urandom);
            start = 1'($urandom);
            expect_cycle("fetch", 1, (k == d), 1, 2'b00, 0, 0, 2'b00);
            tick();
            if (k == d) begin
                acked = 1;
                break;
            end
        end
        if (!acked) begin
            fault_hold(2'b10);
            return;
        end
        op = opc;
        ack = 1'($urandom);
        start = 1'($urandom);
        expect_cycle("decode", 0, 0, 1, 2'b00, 0, 0, 2'b00);
        tick();
        if (opc != OP_R && opc != OP_I) begin
            fault_hold(2'b01);
            return;
        end
        noise();
        start = 1'($urandom);
        expect_cycle("exec", 0, 0, 1, is_r ? 2'b10 : 2'b00, !is_r, 0, 2'b00);
        if (rst_exec) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            start = 1'b0;
            exp_ret = 0;
            noise();
            expect_cycle("rst_exec", 0, 0, 0, 2'b00, 0, 0, 2'b00);
            tick();
            return;
        end
        tick();
        noise();
        start = cont;
        expect_cycle("wb", 0, 0, 1, is_r ? 2'b10 : 2'b00, !is_r, 1, 2'b00);
        tick();
        exp_ret++;
        in_fetch = cont;
    endtask

    initial begin
        bit f;
        do_reset();
        idle_cycle(0);
        idle_cycle(1);
        instr(0, OP_R, 1, 0, f);
        instr(3, OP_I, 0, 0, f);
        idle_cycle(1);
        instr(1, 7'b0000011, 1, 0, f);
        idle_cycle(1);
        instr(FT, OP_R, 1, 0, f);
        idle_cycle(1);
        instr(FT - 1, OP_R, 0, 0, f);
        idle_cycle(1);
        instr(0, OP_I, 0, 1, f);
        idle_cycle(1);
        for (int i = 0; i < 17; i++)
            instr(0, ($urandom_range(1) != 0) ? OP_R : OP_I, (i < 16), 0, f);
        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(2)) idle_cycle(0);
            idle_cycle(1);
            f = 1;
            while (f) begin
                int d;
                logic [6:0] opc;
                d = ($urandom_range(9) == 0) ? FT - 1 + $urandom_range(1) : $urandom_range(4);
                opc = ($urandom_range(9) < 8) ? (($urandom_range(1) != 0) ? OP_R : OP_I) : 7'($urandom);
                instr(d, opc, 1'($urandom_range(3) != 0), ($urandom_range(9) == 0), f);
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
